// File: rtl/vga_pixel_pipe_pkg.sv
// Shared VGA timing defaults, framebuffer geometry and the delay-line payload.
// Latency/backpressure: none here (declarations only).
package vga_pkg;

   localparam int H_VISIBLE    = 640;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 752;
   localparam int H_TOTAL      = 800;
   localparam int V_VISIBLE    = 480;
   localparam int V_SYNC_START = 490;
   localparam int V_SYNC_END   = 492;
   localparam int V_TOTAL      = 525;

   localparam int DEF_SCALE_SHIFT = 1;
   localparam int FB_W  = H_VISIBLE >> DEF_SCALE_SHIFT;
   localparam int FB_H  = V_VISIBLE >> DEF_SCALE_SHIFT;
   localparam int RGB_W = 12;
   localparam int CH_W  = 4;

   function automatic int calc_addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic             hs;
      logic             vs;
      logic             active;
      logic             frame_start;
      logic             synced;
      logic             enable;
      logic [RGB_W-1:0] bg;
   } pipe_t;

   localparam pipe_t PIPE_RST = '{hs: 1'b1, vs: 1'b1, active: 1'b0, frame_start: 1'b0,
                                  synced: 1'b0, enable: 1'b0, bg: '0};

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Framebuffer read port: address/strobe out of the pipe, pixel data back in.
// Fixed-latency read, no backpressure.
interface vga_pixel_pipe_if
   import vga_pkg::*;
#(
   parameter int ADDR_W = 17
);
   logic [ADDR_W-1:0] oAddr;
   logic              oRdEn;
   logic [RGB_W-1:0]  iRdData;

   modport master (output oAddr, output oRdEn, input iRdData);
   modport slave  (input oAddr, input oRdEn, output iRdData);
endinterface

// File: rtl/vga_pixel_pipe_delay_line.sv
// Generic reset-to-constant shift register; latency DEPTH cycles, no backpressure.
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_dat,
   output logic [WIDTH-1:0] o_dat
);
   logic [WIDTH-1:0] r_pipe [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VAL;
      end else begin
         r_pipe[0] <= i_dat;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_dat = r_pipe[DEPTH-1];
endmodule

// File: rtl/vga_pixel_pipe.sv
// Framebuffer fetch and RGB/sync output stage behind the VGA timing generator.
// Latency MEM_LAT+2 from counters to every output; free-running, no backpressure.
module vga_pixel_pipe
   import vga_pkg::*;
#(
   parameter int WIDTH       = H_VISIBLE,
   parameter int HEIGHT      = V_VISIBLE,
   parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int MEM_LAT     = 2,
   parameter int ADDR_W      = calc_addr_w((WIDTH >> SCALE_SHIFT) * (HEIGHT >> SCALE_SHIFT))
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic [9:0]       iCountH,
   input  logic [9:0]       iCountV,
   input  logic             iHS,
   input  logic             iVS,
   input  logic             iEnable,
   input  logic [RGB_W-1:0] iBgColor,
   vga_pixel_pipe_if.master fb,
   output logic [CH_W-1:0]  oRed,
   output logic [CH_W-1:0]  oGreen,
   output logic [CH_W-1:0]  oBlue,
   output logic             oHS,
   output logic             oVS,
   output logic             oFrameStart
);
   localparam int              L       = MEM_LAT + 2;
   localparam logic [9:0]      H_ACT   = 10'(WIDTH);
   localparam logic [9:0]      V_ACT   = 10'(HEIGHT);
   localparam logic [9:0]      H_LAST  = 10'(WIDTH - 1);
   localparam logic [9:0]      V_MASK  = 10'((1 << SCALE_SHIFT) - 1);
   localparam logic [ADDR_W-1:0] FB_STEP = ADDR_W'(WIDTH >> SCALE_SHIFT);

   logic              w_frame_start;
   logic              w_active;
   logic              w_synced;
   logic              w_enable;
   logic [RGB_W-1:0]  w_bg;
   logic [RGB_W-1:0]  w_rgb;
   pipe_t             w_pipe_in;
   pipe_t             w_pipe_out;

   logic              r_synced;
   logic              r_enable;
   logic [RGB_W-1:0]  r_bg;
   logic [ADDR_W-1:0] r_line_base;

   // The frame-start cycle already sees the freshly loaded shadow values.
   always_comb begin
      w_frame_start = (iCountH == '0) && (iCountV == '0);
      w_active      = (iCountH < H_ACT) && (iCountV < V_ACT);
      w_synced      = w_frame_start ? 1'b1     : r_synced;
      w_enable      = w_frame_start ? iEnable  : r_enable;
      w_bg          = w_frame_start ? iBgColor : r_bg;
      w_pipe_in     = '{hs: iHS, vs: iVS, active: w_active, frame_start: w_frame_start,
                        synced: w_synced, enable: w_enable, bg: w_bg};
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_synced    <= 1'b0;
         r_enable    <= 1'b0;
         r_bg        <= '0;
         r_line_base <= '0;
         fb.oAddr    <= '0;
         fb.oRdEn    <= 1'b0;
      end else begin
         r_synced <= w_synced;
         r_enable <= w_enable;
         r_bg     <= w_bg;
         // Each framebuffer row is reused for 2^SCALE_SHIFT output lines.
         if (iCountV >= V_ACT)
            r_line_base <= '0;
         else if ((iCountH == H_LAST) && ((iCountV & V_MASK) == V_MASK))
            r_line_base <= r_line_base + FB_STEP;
         fb.oAddr <= r_line_base + ADDR_W'(iCountH >> SCALE_SHIFT);
         fb.oRdEn <= w_active && w_synced && w_enable;
      end
   end

   // One stage short of L: the output register supplies the last cycle.
   vga_delay_line #(
      .WIDTH     ($bits(pipe_t)),
      .DEPTH     (L - 1),
      .RESET_VAL (PIPE_RST)
   ) u_delay (
      .i_clk   (iClk),
      .i_rst_n (iRstN),
      .i_dat   (w_pipe_in),
      .o_dat   (w_pipe_out)
   );

   always_comb begin
      w_rgb = '0;
      if (w_pipe_out.active && w_pipe_out.synced)
         w_rgb = w_pipe_out.enable ? fb.iRdData : w_pipe_out.bg;
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oRed        <= '0;
         oGreen      <= '0;
         oBlue       <= '0;
         oHS         <= 1'b1;
         oVS         <= 1'b1;
         oFrameStart <= 1'b0;
      end else begin
         {oRed, oGreen, oBlue} <= w_rgb;
         oHS                   <= w_pipe_out.hs;
         oVS                   <= w_pipe_out.vs;
         oFrameStart           <= w_pipe_out.frame_start;
      end
   end
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe with a fixed-latency framebuffer model.
module tb_vga_pixel_pipe;
   import vga_pkg::*;

   localparam int MEM_LAT = 2;
   localparam int L       = MEM_LAT + 2;
   localparam int AW      = 17;

   logic        iClk = 1'b0;
   logic        iRstN = 1'b1;
   logic [9:0]  iCountH = '0;
   logic [9:0]  iCountV = '0;
   logic        iHS = 1'b1;
   logic        iVS = 1'b1;
   logic        iEnable = 1'b0;
   logic [11:0] iBgColor = '0;
   logic [3:0]  oRed, oGreen, oBlue;
   logic        oHS, oVS, oFrameStart;

   vga_pixel_pipe_if #(.ADDR_W(AW)) fb_if ();

   vga_pixel_pipe #(
      .WIDTH(640), .HEIGHT(480), .SCALE_SHIFT(1), .MEM_LAT(MEM_LAT), .ADDR_W(AW)
   ) dut (
      .iClk(iClk), .iRstN(iRstN), .iCountH(iCountH), .iCountV(iCountV),
      .iHS(iHS), .iVS(iVS), .iEnable(iEnable), .iBgColor(iBgColor),
      .fb(fb_if), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
      .oHS(oHS), .oVS(oVS), .oFrameStart(oFrameStart)
   );

   always #5 iClk = ~iClk;

   int checks = 0;
   int failures = 0;
   int mem_mode = 0;  // 0: every address reads FFF, 1: address echo

   // Framebuffer: data for a read appears MEM_LAT cycles after the strobe; junk otherwise.
   logic [AW-1:0] mem_a [MEM_LAT];
   logic          mem_v [MEM_LAT];
   logic [11:0]   junk;
   always @(posedge iClk) begin
      mem_a[0] <= fb_if.oAddr;
      mem_v[0] <= fb_if.oRdEn;
      junk     <= 12'($urandom);
      for (int i = 1; i < MEM_LAT; i++) begin
         mem_a[i] <= mem_a[i-1];
         mem_v[i] <= mem_v[i-1];
      end
   end
   assign fb_if.iRdData = (mem_v[MEM_LAT-1] !== 1'b1) ? junk :
                          (mem_mode == 0) ? 12'hFFF : mem_a[MEM_LAT-1][11:0];

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        fs;
      int          x;
      int          y;
   } exp_t;

   exp_t        exp_q[$];
   bit          m_synced;
   bit          m_en;
   logic [11:0] m_bg;

   task automatic set_in(input int h, input int v);
      iCountH = 10'(h);
      iCountV = 10'(v);
      iHS     = !(h >= H_SYNC_START && h < H_SYNC_END);
      iVS     = !(v >= V_SYNC_START && v < V_SYNC_END);
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Outputs right after reset come from the cleared pipeline for L-1 cycles.
   task automatic model_reset();
      exp_t r;
      r.rgb = '0; r.hs = 1'b1; r.vs = 1'b1; r.fs = 1'b0; r.x = -1; r.y = -1;
      exp_q.delete();
      for (int i = 0; i < L - 1; i++) exp_q.push_back(r);
      m_synced = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge iClk);
      #3 iRstN = 1'b0;
      repeat (2) @(posedge iClk);
      #1 iRstN = 1'b1;
      model_reset();
   endtask

   function automatic int next_h(input int h);
      int keys [9];
      int n;
      keys = '{639, 640, 655, 656, 657, 751, 752, 798, 799};
      n = h + int'($urandom_range(1, 96));
      for (int i = 0; i < 9; i++) begin
         if (keys[i] > h && keys[i] < n) begin
            n = keys[i];
            break;
         end
      end
      return n;
   endfunction

   // Drives lines g0..g1 (global line index, wraps every V_TOTAL) with random ascending H,
   // checking the read port every cycle and the pixel/sync outputs L cycles later.
   task automatic stream(input int g0, input int h0, input int g1, input int h1,
                         input int chg_line, input logic chg_en, input logic [11:0] chg_bg);
      int v, h, hend, e_addr;
      bit act, fs, e_rd;
      exp_t e;
      for (int g = g0; g <= g1; g++) begin
         v    = g % V_TOTAL;
         h    = (g == g0) ? h0 : 0;
         hend = (g == g1) ? h1 : H_TOTAL - 1;
         if (g == chg_line) begin
            iEnable  = chg_en;
            iBgColor = chg_bg;
         end
         while (h <= hend) begin
            set_in(h, v);
            fs = (h == 0) && (v == 0);
            if (fs) begin
               m_synced = 1'b1;
               m_en     = iEnable;
               m_bg     = iBgColor;
            end
            act    = (h < H_VISIBLE) && (v < V_VISIBLE);
            e_rd   = act && m_synced && m_en;
            e_addr = (v / 2) * 320 + (h / 2);
            e.rgb  = !(act && m_synced) ? 12'h000 :
                     !m_en ? m_bg : (mem_mode == 0) ? 12'hFFF : 12'(e_addr);
            e.hs = iHS; e.vs = iVS; e.fs = fs; e.x = h; e.y = v;
            exp_q.push_back(e);
            tick();
            checks++;
            if (fb_if.oRdEn !== e_rd) begin
               failures++;
               $display("FAIL rd_en x=%0d y=%0d got=%b want=%b", h, v, fb_if.oRdEn, e_rd);
            end
            if (e_rd) begin
               checks++;
               if (fb_if.oAddr !== AW'(e_addr)) begin
                  failures++;
                  $display("FAIL addr x=%0d y=%0d got=%0d want=%0d", h, v, fb_if.oAddr, e_addr);
               end
            end
            if (exp_q.size() == L) begin
               e = exp_q.pop_front();
               checks++;
               if ({oRed, oGreen, oBlue, oHS, oVS, oFrameStart} !== {e.rgb, e.hs, e.vs, e.fs}) begin
                  failures++;
                  $display("FAIL pixel x=%0d y=%0d got rgb=%h hs=%b vs=%b fs=%b want rgb=%h hs=%b vs=%b fs=%b",
                           e.x, e.y, {oRed, oGreen, oBlue}, oHS, oVS, oFrameStart,
                           e.rgb, e.hs, e.vs, e.fs);
               end
            end
            h = next_h(h);
         end
      end
   endtask

   task automatic test_reset();
      iEnable = 1'b1; iBgColor = 12'hABC;
      set_in(0, 0);
      iHS = 1'b0; iVS = 1'b0;
      #2 iRstN = 1'b0;
      #1;
      checks++;
      if ({oRed, oGreen, oBlue} !== 12'h000) begin
         failures++; $display("FAIL reset_rgb got=%h want=000", {oRed, oGreen, oBlue});
      end
      checks++;
      if ({oHS, oVS} !== 2'b11) begin
         failures++; $display("FAIL reset_sync got=%b want=11", {oHS, oVS});
      end
      checks++;
      if (fb_if.oAddr !== '0) begin
         failures++; $display("FAIL reset_addr got=%0d want=0", fb_if.oAddr);
      end
      checks++;
      if (fb_if.oRdEn !== 1'b0) begin
         failures++; $display("FAIL reset_rden got=%b want=0", fb_if.oRdEn);
      end
      checks++;
      if (oFrameStart !== 1'b0) begin
         failures++; $display("FAIL reset_fs got=%b want=0", oFrameStart);
      end
      repeat (3) @(posedge iClk);
      #1;
      checks++;
      if ({oHS, oVS, fb_if.oRdEn, oFrameStart} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_held got=%b want=1100", {oHS, oVS, fb_if.oRdEn, oFrameStart});
      end
      iRstN = 1'b1;
      model_reset();
   endtask

   task automatic test_addr();
      do_reset();
      iEnable = 1'b1; iBgColor = '0;
      set_in(0, 0); tick();
      checks++;
      if ({fb_if.oRdEn, fb_if.oAddr} !== {1'b1, 17'd0}) begin
         failures++; $display("FAIL addr_h0v0 got en=%b addr=%0d want en=1 addr=0", fb_if.oRdEn, fb_if.oAddr);
      end
      set_in(2, 0); tick();
      checks++;
      if (fb_if.oAddr !== 17'd1) begin
         failures++; $display("FAIL addr_h2v0 got=%0d want=1", fb_if.oAddr);
      end
      set_in(639, 0); tick();
      checks++;
      if (fb_if.oAddr !== 17'd319) begin
         failures++; $display("FAIL addr_h639v0 got=%0d want=319", fb_if.oAddr);
      end
      set_in(640, 0); tick();
      checks++;
      if (fb_if.oRdEn !== 1'b0) begin
         failures++; $display("FAIL rden_h640 got=%b want=0", fb_if.oRdEn);
      end
      set_in(639, 1); tick();
      set_in(0, 2); tick();
      checks++;
      if ({fb_if.oRdEn, fb_if.oAddr} !== {1'b1, 17'd320}) begin
         failures++; $display("FAIL addr_h0v2 got en=%b addr=%0d want en=1 addr=320", fb_if.oRdEn, fb_if.oAddr);
      end
      for (int v = 2; v < 479; v++) begin
         set_in(639, v); tick();
      end
      set_in(639, 479); tick();
      checks++;
      if ({fb_if.oRdEn, fb_if.oAddr} !== {1'b1, 17'd76799}) begin
         failures++; $display("FAIL addr_last got en=%b addr=%0d want en=1 addr=76799", fb_if.oRdEn, fb_if.oAddr);
      end
      set_in(0, 480); tick();
      checks++;
      if (fb_if.oRdEn !== 1'b0) begin
         failures++; $display("FAIL rden_v480 got=%b want=0", fb_if.oRdEn);
      end
   endtask

   task automatic test_sync_latency();
      int fs_at, fs_count, hs_in, hs_out, h;
      do_reset();
      iEnable = 1'b1;
      fs_at = -1; fs_count = 0;
      for (int i = 0; i < 12; i++) begin
         set_in(i, 0); tick();
         if (oFrameStart === 1'b1) begin
            fs_count++;
            if (fs_at < 0) fs_at = i + 1;
         end
      end
      checks++;
      if (fs_at != L) begin
         failures++; $display("FAIL fs_latency got=%0d want=%0d", fs_at, L);
      end
      checks++;
      if (fs_count != 1) begin
         failures++; $display("FAIL fs_pulses got=%0d want=1", fs_count);
      end
      hs_in = -1; hs_out = -1;
      for (int i = 0; i < 20; i++) begin
         h = 648 + i;
         set_in(h, 100);
         if (h == H_SYNC_START) hs_in = i;
         tick();
         if (oHS === 1'b0 && hs_out < 0) hs_out = i + 1;
      end
      checks++;
      if (hs_out < 0 || hs_out - hs_in != L) begin
         failures++; $display("FAIL hs_latency got=%0d want=%0d", hs_out - hs_in, L);
      end
   endtask

   task automatic test_fff_frames();
      do_reset();
      mem_mode = 0; iEnable = 1'b1; iBgColor = 12'h123;
      stream(0, 0, V_TOTAL + 2, H_TOTAL - 1, 100, 1'b0, 12'h456);
   endtask

   task automatic test_echo_frames();
      do_reset();
      mem_mode = 1; iEnable = 1'b1; iBgColor = 12'h000;
      stream(0, 0, 2 * V_TOTAL + 1, H_TOTAL - 1, -1, 1'b1, 12'h000);
   endtask

   task automatic test_bg_frames();
      do_reset();
      mem_mode = 1; iEnable = 1'b0; iBgColor = 12'h0F0;
      stream(0, 0, V_TOTAL + 60, H_TOTAL - 1, 200, 1'b0, 12'hF00);
   endtask

   task automatic test_reset_midframe();
      do_reset();
      mem_mode = 0; iEnable = 1'b1; iBgColor = 12'h000;
      stream(0, 0, 10, 300, -1, 1'b1, 12'h000);
      #2 iRstN = 1'b0;
      #1;
      checks++;
      if ({oRed, oGreen, oBlue, oHS, oVS, oFrameStart} !== {12'h000, 3'b110}) begin
         failures++;
         $display("FAIL midreset_out got rgb=%h hs=%b vs=%b fs=%b want rgb=000 hs=1 vs=1 fs=0",
                  {oRed, oGreen, oBlue}, oHS, oVS, oFrameStart);
      end
      checks++;
      if ({fb_if.oRdEn, fb_if.oAddr} !== {1'b0, 17'd0}) begin
         failures++; $display("FAIL midreset_rd got en=%b addr=%0d want en=0 addr=0", fb_if.oRdEn, fb_if.oAddr);
      end
      @(posedge iClk);
      #1 iRstN = 1'b1;
      model_reset();
      stream(10, 301, V_TOTAL + 8, H_TOTAL - 1, -1, 1'b1, 12'h000);
   endtask

   initial begin
      test_reset();
      test_addr();
      test_sync_latency();
      test_fff_frames();
      test_echo_frames();
      test_bg_frames();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/vga_pixel_pipe.md
Name: vga_pixel_pipe

Overview:
- Sits directly downstream of the VGA timing generator. Consumes its horizontal/vertical counters and active-low syncs.
- Generates framebuffer read addresses for a 2^SCALE_SHIFT-upscaled framebuffer and captures the returned pixel data.
- Drives 12-bit RGB and syncs to the connector, with all outputs aligned to one fixed pipeline latency.
- Per-frame control inputs are shadowed at frame start, so they never change mid-frame.

Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines per frame
- SCALE_SHIFT, 1, upscale factor log2; framebuffer is (WIDTH>>SCALE_SHIFT) x (HEIGHT>>SCALE_SHIFT)
- MEM_LAT, 2, framebuffer read latency in cycles, from oAddr/oRdEn to valid iRdData; legal range 1..4
- ADDR_W, 17, framebuffer address width; must hold FB_W*FB_H-1

Ports:
- iClk  in  1  pixel clock
- iRstN  in  1  reset; asynchronous, active-low
- iCountH  in  10  horizontal counter from timing generator
- iCountV  in  10  vertical counter from timing generator
- iHS  in  1  hsync, active-low
- iVS  in  1  vsync, active-low
- iEnable  in  1  1 = show framebuffer, 0 = show iBgColor; shadowed at frame start
- iBgColor  in  12  {R,G,B} 4 bits each; shadowed at frame start
- oAddr  out  ADDR_W  framebuffer read address
- oRdEn  out  1  framebuffer read strobe
- iRdData  in  12  framebuffer pixel {R,G,B}
- oRed  out  4  red channel to connector
- oGreen  out  4  green channel to connector
- oBlue  out  4  blue channel to connector
- oHS  out  1  delayed hsync
- oVS  out  1  delayed vsync
- oFrameStart  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset: iClk and asynchronous active-low iRstN. While iRstN=0 all registers clear, with these reset values:
  - oHS = oVS = 1 (inactive).
  - oRed/oGreen/oBlue = 0, oAddr = 0, oRdEn = 0, oFrameStart = 0.
  - Shadow enable = 0, shadow bg = 0, line base = 0, rSynced = 0.
- Input frame start: iCountH==0 && iCountV==0. On that cycle:
  - Load the shadow registers from iEnable and iBgColor.
  - Set rSynced = 1.
- Active: iCountH<WIDTH && iCountV<HEIGHT.
- Stage 1 (registered, latency 1):
  - oAddr = rLineBase + (iCountH>>SCALE_SHIFT), truncated to ADDR_W.
  - oRdEn = active && rSynced && shadowEnable.
  - The frame-start cycle itself uses the newly loaded shadow values and rSynced=1.
- Line base (no multiplier): rLineBase steps by FB_W = WIDTH>>SCALE_SHIFT.
  - Advance: rLineBase += FB_W when iCountH==WIDTH-1 && iCountV<HEIGHT && iCountV[SCALE_SHIFT-1:0] all ones.
  - Clear: rLineBase = 0 whenever iCountV>=HEIGHT.
  - The clear has priority over the advance.
- Total latency L = MEM_LAT+2 from input counters to RGB/sync outputs.
  - Active, HS, VS and frame start pass through an L-deep delay line.
  - Delay-line reset state: syncs = 1, others = 0.
- Output stage (registered): RGB = delayed active && rSynced_d ? (shadowEnable_d ? iRdData : shadowBg_d) : 12'h000.
  - Blanking is always black, regardless of iRdData.
  - Shadow values travel down the delay line, so a frame-start update never affects pixels of the previous frame still in flight.
- oFrameStart: the input frame-start event delayed by L; asserted exactly on the cycle output pixel (0,0) is presented.
- Reset mid-frame:
  - oRdEn stays 0 and RGB stays black until the next input frame start, because rSynced gates both.
  - Syncs resume following the inputs L cycles after reset release.
- Counter values beyond the total line/frame length are not expected; the block does not check for them.

Decomposition:
- Package vga_pkg holds:
  - timing defaults (WIDTH, HEIGHT, porch/pulse values);
  - localparams FB_W, FB_H, RGB_W=12, CH_W=4;
  - a function computing ADDR_W from FB_W*FB_H.
- One sub-module, vga_delay_line: parameterised WIDTH/DEPTH/RESET_VAL shift register. It carries {hs, vs, active, frameStart, synced, enable, bg} for L cycles.

Test Plan:
- Reset asserted mid-line → all outputs at reset values immediately (async). After release, RGB stays 0 and oRdEn stays 0 until the counters pass (0,0).
- Defaults, iEnable=1, counters at (H=0,V=0) → next cycle oAddr=0, oRdEn=1. (H=2,V=0) → oAddr=1. (H=0,V=2) → oAddr=320. (H=639,V=479) → oAddr=76799. (H=0,V=480) → oRdEn=0.
- MEM_LAT=2 → iHS falls when H=656; oHS falls exactly 4 cycles later. oFrameStart pulses 4 cycles after input (0,0).
- Memory model returns 12'hFFF for every address → RGB=FFF during active, 000 during blanking (H=640..799 and V=480..524).
- iEnable=0, iBgColor=12'h0F0 held before frame start → every active pixel is R=0 G=F B=0 and oRdEn stays 0. Changing iBgColor to 12'hF00 mid-frame takes effect only from the next oFrameStart.
- Run two full frames (800x525 cycles each) with an address-echo memory → output pixel (x,y) equals (y>>1)*320+(x>>1) truncated to 12 bits. No drift at frame wrap.
